// File: rtl/ex_alu.sv
// Execute-stage ALU: single-cycle logic/arith/compare/branch ops and an
// iterative 1-bit-per-cycle shifter, behind a registered valid/ready output.
module ex_alu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            branch_taken,
  output logic            dbg_state
);

  localparam logic [4:0] OP_ADD  = 5'd1,  OP_SUB  = 5'd2,  OP_SLL  = 5'd3,
                         OP_SLT  = 5'd4,  OP_SLTU = 5'd5,  OP_XOR  = 5'd6,
                         OP_SRL  = 5'd7,  OP_SRA  = 5'd8,  OP_OR   = 5'd9,
                         OP_AND  = 5'd10, OP_BEQ  = 5'd11, OP_BNE  = 5'd12,
                         OP_BLT  = 5'd13, OP_BGE  = 5'd14, OP_BLTU = 5'd15,
                         OP_BGEU = 5'd16;

  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  // Handshake: an op transfers on a rising edge where in_valid && in_ready;
  // a result transfers on a rising edge where out_valid && out_ready.
  state_e            state_q;
  logic [4:0]        cnt_q;
  logic [4:0]        op_q;
  logic [XLEN-1:0]   work_q;
  logic              out_valid_q;
  logic [XLEN-1:0]   result_q;
  logic              taken_q;

  logic [4:0]        shamt;
  logic              is_shift;
  logic              start_shift;
  logic              accept;
  logic [XLEN-1:0]   res_d;
  logic              taken_d;
  logic [XLEN-1:0]   work_d;

  assign shamt       = src2[4:0];
  assign is_shift    = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
  assign start_shift = is_shift && (shamt != 5'd0);
  assign in_ready    = rst_n && !flush && (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept      = in_valid && in_ready;

  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign branch_taken = taken_q;
  assign dbg_state    = (state_q == S_SHIFT);

  always_comb begin
    res_d   = '0;
    taken_d = 1'b0;
    case (alu_op)
      OP_ADD:  res_d = src1 + src2;
      OP_SUB:  res_d = src1 - src2;
      OP_SLL, OP_SRL, OP_SRA: res_d = src1;  // only reached with shamt == 0
      OP_SLT:  res_d = {{(XLEN-1){1'b0}}, $signed(src1) < $signed(src2)};
      OP_SLTU: res_d = {{(XLEN-1){1'b0}}, src1 < src2};
      OP_XOR:  res_d = src1 ^ src2;
      OP_OR:   res_d = src1 | src2;
      OP_AND:  res_d = src1 & src2;
      OP_BEQ:  taken_d = (src1 == src2);
      OP_BNE:  taken_d = (src1 != src2);
      OP_BLT:  taken_d = ($signed(src1) < $signed(src2));
      OP_BGE:  taken_d = ($signed(src1) >= $signed(src2));
      OP_BLTU: taken_d = (src1 < src2);
      OP_BGEU: taken_d = (src1 >= src2);
      default: ;
    endcase
    if (alu_op >= OP_BEQ && alu_op <= OP_BGEU) begin
      res_d = {{(XLEN-1){1'b0}}, taken_d};
    end
  end

  always_comb begin
    work_d = work_q;
    case (op_q)
      OP_SLL:  work_d = {work_q[XLEN-2:0], 1'b0};
      OP_SRL:  work_d = {1'b0, work_q[XLEN-1:1]};
      OP_SRA:  work_d = {work_q[XLEN-1], work_q[XLEN-1:1]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      op_q        <= 5'd0;
      work_q      <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      taken_q     <= 1'b0;
    end else if (flush) begin
      // Kill wins over everything; the last result stays visible but invalid.
      state_q     <= S_IDLE;
      cnt_q       <= 5'd0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (start_shift) begin
              state_q     <= S_SHIFT;
              work_q      <= src1;
              cnt_q       <= shamt;
              op_q        <= alu_op;
              out_valid_q <= 1'b0;
            end else begin
              result_q    <= res_d;
              taken_q     <= taken_d;
              out_valid_q <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        S_SHIFT: begin
          work_q <= work_d;
          cnt_q  <= cnt_q - 5'd1;
          // Last step: publish the shifted value directly on this edge.
          if (cnt_q == 5'd1) begin
            result_q    <= work_d;
            taken_q     <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_alu.sv
// Bench for ex_alu: directed scenario tasks plus a randomized run checked
// against a plain-arithmetic reference model through an expected queue.
module tb_ex_alu;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        branch_taken;
  logic        dbg_state;

  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];

  ex_alu #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .src1(src1), .src2(src2), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  // Returns {taken, result} from the ISA-level meaning of each code.
  function automatic logic [32:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic        t;
    int          sh;
    r  = 32'd0;
    t  = 1'b0;
    sh = int'(b[4:0]);
    case (op)
      5'd1:  r = a + b;
      5'd2:  r = a - b;
      5'd3:  r = a << sh;
      5'd4:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd5:  r = (a < b) ? 32'd1 : 32'd0;
      5'd6:  r = a ^ b;
      5'd7:  r = a >> sh;
      5'd8:  r = $signed(a) >>> sh;
      5'd9:  r = a | b;
      5'd10: r = a & b;
      5'd11: t = (a == b);
      5'd12: t = (a != b);
      5'd13: t = ($signed(a) < $signed(b));
      5'd14: t = ($signed(a) >= $signed(b));
      5'd15: t = (a < b);
      5'd16: t = (a >= b);
      default: ;
    endcase
    if (op >= 5'd11 && op <= 5'd16) r = t ? 32'd1 : 32'd0;
    return {t, r};
  endfunction

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    in_valid = 0; alu_op = 0; src1 = 0; src2 = 0; flush = 0; out_ready = 1;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", out_valid); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h need 00000000", result); end
    checks++; if (branch_taken !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b need 0", branch_taken); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b need 0", in_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b need 1", in_ready); end
    checks++; if (dbg_state !== 1'b0) begin errors++; $display("FAIL reset_state: got %b need 0", dbg_state); end
  endtask

  task automatic test_arith_wrap();
    out_ready = 1;
    in_valid = 1; alu_op = 5'd1; src1 = 32'h7FFF_FFFF; src2 = 32'h0000_0001;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b need 1", in_ready); end
    tick();
    alu_op = 5'd2; src1 = 32'h0; src2 = 32'h1;
    checks++; if (out_valid !== 1'b1 || result !== 32'h8000_0000)
      begin errors++; $display("FAIL add_wrap: got v=%b r=%h need v=1 r=80000000", out_valid, result); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || result !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL sub_wrap: got v=%b r=%h need v=1 r=ffffffff", out_valid, result); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_valid: got %b need 0", out_valid); end
  endtask

  task automatic test_shift();
    logic [31:0] a;
    out_ready = 1;
    in_valid = 1; alu_op = 5'd8; src1 = 32'h8000_0000; src2 = 32'h0000_0024;
    tick();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
        begin errors++; $display("FAIL sra_busy[%0d]: got rdy=%b v=%b need rdy=0 v=0", i, in_ready, out_valid); end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || result !== 32'hF800_0000 || branch_taken !== 1'b0)
      begin errors++; $display("FAIL sra_result: got v=%b r=%h t=%b need v=1 r=f8000000 t=0", out_valid, result, branch_taken); end
    a = $urandom;
    in_valid = 1; alu_op = 5'd3; src1 = a; src2 = 32'h0000_0060;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || result !== a)
      begin errors++; $display("FAIL sll_zero: got v=%b r=%h need v=1 r=%h", out_valid, result, a); end
    tick();
  endtask

  task automatic test_compare_branch();
    logic [4:0]  ops [6];
    logic [31:0] er  [6];
    logic        et  [6];
    ops[0] = 5'd13; er[0] = 32'd1; et[0] = 1'b1;
    ops[1] = 5'd15; er[1] = 32'd0; et[1] = 1'b0;
    ops[2] = 5'd4;  er[2] = 32'd1; et[2] = 1'b0;
    ops[3] = 5'd5;  er[3] = 32'd0; et[3] = 1'b0;
    ops[4] = 5'd11; er[4] = 32'd1; et[4] = 1'b1;
    ops[5] = 5'd20; er[5] = 32'd0; et[5] = 1'b0;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1; alu_op = ops[i]; src1 = 32'hFFFF_FFFF;
      src2 = (i == 4) ? 32'hFFFF_FFFF : 32'h0000_0001;
      tick();
      checks++; if (out_valid !== 1'b1 || result !== er[i] || branch_taken !== et[i])
        begin errors++; $display("FAIL cmp_op%0d: got v=%b r=%h t=%b need v=1 r=%h t=%b",
                                 ops[i], out_valid, result, branch_taken, er[i], et[i]); end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    out_ready = 1;
    in_valid = 1; alu_op = 5'd10; src1 = 32'hF0F0_F0F0; src2 = 32'h0000_FFFF;
    tick();
    a = $urandom; b = $urandom;
    out_ready = 0; alu_op = 5'd6; src1 = a; src2 = b;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 32'h0000_F0F0)
        begin errors++; $display("FAIL bp_hold[%0d]: got rdy=%b v=%b r=%h need rdy=0 v=1 r=0000f0f0", i, in_ready, out_valid, result); end
      tick();
    end
    out_ready = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b need 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || result !== (a ^ b))
      begin errors++; $display("FAIL bp_xor: got v=%b r=%h need v=1 r=%h", out_valid, result, a ^ b); end
    tick();
  endtask

  task automatic test_flush_mid_shift();
    logic [31:0] prev, a, b;
    int late;
    out_ready = 1;
    in_valid = 1; alu_op = 5'd3; src1 = $urandom | 32'h1; src2 = 32'd31;
    tick();
    in_valid = 0;
    prev = result;
    repeat (9) tick();
    flush = 1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready_low: got %b need 0", in_ready); end
    tick();
    flush = 0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== prev)
      begin errors++; $display("FAIL flush_after: got v=%b rdy=%b r=%h need v=0 rdy=1 r=%h", out_valid, in_ready, result, prev); end
    a = $urandom; b = $urandom;
    in_valid = 1; alu_op = 5'd1; src1 = a; src2 = b;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || result !== a + b)
      begin errors++; $display("FAIL flush_add: got v=%b r=%h need v=1 r=%h", out_valid, result, a + b); end
    late = 0;
    repeat (30) begin
      tick();
      if (out_valid === 1'b1) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL flush_late_valid: got %0d valid cycles need 0", late); end
  endtask

  task automatic test_reset_mid_shift();
    int late;
    out_ready = 1;
    in_valid = 1; alu_op = 5'd11; src1 = 32'h1234; src2 = 32'h1234;
    tick();
    alu_op = 5'd7; src1 = $urandom | 32'h8000_0000; src2 = 32'd20;
    tick();
    in_valid = 0;
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || result !== 32'd0 || branch_taken !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL rst_mid: got v=%b r=%h t=%b rdy=%b need v=0 r=0 t=0 rdy=0", out_valid, result, branch_taken, in_ready); end
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();
    checks++; if (in_ready !== 1'b1 || dbg_state !== 1'b0)
      begin errors++; $display("FAIL rst_release: got rdy=%b st=%b need rdy=1 st=0", in_ready, dbg_state); end
    late = 0;
    repeat (25) begin
      tick();
      if (out_valid === 1'b1) late++;
    end
    checks++; if (late != 0) begin errors++; $display("FAIL rst_late_valid: got %0d valid cycles need 0", late); end
  endtask

  task automatic test_random();
    logic [32:0] exp;
    int budget;
    for (int n = 0; n < 400; n++) begin
      flush     = ($urandom_range(0, 19) == 0);
      out_ready = flush ? 1'b0 : ($urandom_range(0, 3) != 0);
      in_valid  = $urandom_range(0, 1);
      alu_op    = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(17, 31)) : 5'($urandom_range(0, 16));
      src1      = $urandom;
      src2      = ($urandom_range(0, 3) == 0) ? src1 : $urandom;
      #1;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_spurious[%0d]: got r=%h with no op outstanding", n, result);
        end else begin
          exp = exp_q.pop_front();
          if ({branch_taken, result} !== exp) begin
            errors++; $display("FAIL rnd_out[%0d]: got t=%b r=%h need t=%b r=%h", n, branch_taken, result, exp[32], exp[31:0]);
          end
        end
      end
      if (flush) exp_q.delete();
      if (in_valid && in_ready) exp_q.push_back(ref_alu(alu_op, src1, src2));
      tick();
    end
    flush = 0; in_valid = 0; out_ready = 1;
    budget = 0;
    while (exp_q.size() != 0 && budget < 40) begin
      #1;
      if (out_valid) begin
        exp = exp_q.pop_front();
        checks++;
        if ({branch_taken, result} !== exp) begin
          errors++; $display("FAIL rnd_drain: got t=%b r=%h need t=%b r=%h", branch_taken, result, exp[32], exp[31:0]);
        end
      end
      tick();
      budget++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL rnd_timeout: got %0d results outstanding need 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_arith_wrap();
    test_shift();
    test_compare_branch();
    test_backpressure();
    test_flush_mid_shift();
    test_reset_mid_shift();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
